// File: rtl/cic_comp_pkg.sv
// -----------------------------------------------------------------------------
// cic_comp_pkg
// Shared definitions for the CIC droop-compensation FIR and future FIR stages:
//   - state_e          : FSM states of the serial-MAC filter
//   - COEF_FRAC        : number of fractional bits in the Q2.14 coefficients
//   - CIC_COMP_COEFS   : default 12-tap droop-compensation coefficient set
//   - default_coef()   : table lookup that returns 0 beyond the table
//   - round_sat()      : round-half-up, shift and saturate an accumulator
// -----------------------------------------------------------------------------
package cic_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_e;

    localparam int COEF_FRAC    = 14;
    localparam int DEFAULT_TAPS = 12;

    // Symmetric taps with unity DC gain (sum = 0x4000) and a mild
    // high-frequency lift to flatten the CIC sinc droop.
    localparam logic signed [15:0] CIC_COMP_COEFS [DEFAULT_TAPS] = '{
        16'shFF80, 16'sh0100, 16'shFE00, 16'sh0400, 16'shF800, 16'sh2580,
        16'sh2580, 16'shF800, 16'sh0400, 16'shFE00, 16'sh0100, 16'shFF80
    };

    function automatic logic signed [15:0] default_coef(input int idx);
        if (idx >= 0 && idx < DEFAULT_TAPS) begin
            return CIC_COMP_COEFS[idx];
        end
        return '0;
    endfunction

    // Adds half an LSB of the output scale, shifts arithmetically and clamps
    // to the signed range of an out_w-bit result.
    function automatic logic signed [31:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int out_w);
        logic signed [63:0] rounded;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rounded = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (out_w - 1));
        if (rounded > hi) begin
            return hi[31:0];
        end
        if (rounded < lo) begin
            return lo[31:0];
        end
        return rounded[31:0];
    endfunction

endpackage

// File: rtl/cic_comp_delay_line.sv
// -----------------------------------------------------------------------------
// cic_comp_delay_line
// Circular sample buffer for the serial-MAC FIR.
//   clk, rst_n  : clock, asynchronous active-low reset
//   we_i        : write wr_data_i at the current write pointer
//   wr_data_i   : sample to store
//   adv_i       : advance the write pointer (wraps N_TAPS-1 -> 0)
//   tap_i       : tap offset k; rd_data_o = x[(wr_ptr - k) mod N_TAPS]
//   rd_data_o   : combinational read of the selected tap
// -----------------------------------------------------------------------------
module cic_comp_delay_line #(
    parameter int DATA_WIDTH = 12,
    parameter int N_TAPS     = 12,
    parameter int AW         = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  adv_i,
    input  logic [AW-1:0]         tap_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [N_TAPS];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_idx;

    // Storage and write pointer; the pointer moves only after a computation
    // has consumed the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            if (adv_i) begin
                wr_ptr_q <= (wr_ptr_q == AW'(N_TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
        end
    end

    // Modular subtraction done one bit wider so wr_ptr + N_TAPS cannot wrap.
    always_comb begin
        rd_idx = wr_ptr_q - tap_i;
        if (tap_i > wr_ptr_q) begin
            rd_idx = AW'(({1'b0, wr_ptr_q} + (AW + 1)'(N_TAPS)) - {1'b0, tap_i});
        end
    end

    assign rd_data_o = mem_q[rd_idx];

endmodule

// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
// Serial-MAC FIR that compensates the CIC passband droop. One product per
// clock; one rounded, saturated output per decimated input sample.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   data_in     : signed sample from the CIC
//   data_clk    : CIC decimation clock; a rising edge marks a new sample
//   coef_we     : coefficient write strobe (accepted while coef_ready)
//   coef_addr   : tap index for the write
//   coef_data   : signed Q2.14 coefficient
//   coef_ready  : high while idle, i.e. when a write is accepted
//   data_out    : filtered sample, held between valid pulses
//   data_valid  : one-cycle pulse per new data_out
//   overrun     : sticky, a sample arrived while busy
// -----------------------------------------------------------------------------
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int COEF_WIDTH = 16,
    parameter int N_TAPS     = 12,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(N_TAPS),
    parameter int AW         = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_clk,
    input  logic                  coef_we,
    input  logic [AW-1:0]         coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic                  coef_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  overrun
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;

    state_e                       state_q;
    logic [AW-1:0]                k_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [COEF_WIDTH-1:0] coef_q [N_TAPS];
    logic                         data_clk_q;
    logic [DATA_WIDTH-1:0]        data_out_q;
    logic                         data_valid_q;
    logic                         overrun_q;
    logic                         coef_ready_q;
    logic                         pend_we_q;
    logic [AW-1:0]                pend_addr_q;
    logic [COEF_WIDTH-1:0]        pend_data_q;

    logic                         strobe;
    logic                         capture;
    logic                         advance;
    logic                         coef_wr;
    logic signed [DATA_WIDTH-1:0] x_tap;
    logic signed [PW-1:0]         prod;

    assign strobe  = data_clk & ~data_clk_q;
    assign capture = (state_q == IDLE) && strobe;
    assign advance = (state_q == ROUND);
    assign coef_wr = coef_we && coef_ready_q && (int'(coef_addr) < N_TAPS);

    cic_comp_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_TAPS     (N_TAPS),
        .AW         (AW)
    ) u_delay_line (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (capture),
        .wr_data_i  (data_in),
        .adv_i      (advance),
        .tap_i      (k_q),
        .rd_data_o  (x_tap)
    );

    assign prod  = PW'(x_tap) * PW'(coef_q[k_q]);
    assign acc_d = acc_q + ACC_WIDTH'(prod);

    // Control FSM, MAC datapath and coefficient bank. A write landing in the
    // same cycle as a capture is parked and committed in ROUND so it cannot
    // disturb the computation that just started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            data_clk_q   <= 1'b1;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            coef_ready_q <= 1'b1;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            for (int i = 0; i < N_TAPS; i++) begin
                coef_q[i] <= COEF_WIDTH'(default_coef(i));
            end
        end else begin
            data_clk_q   <= data_clk;
            data_valid_q <= 1'b0;

            if (strobe && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end

            if (coef_wr) begin
                if (strobe) begin
                    pend_we_q   <= 1'b1;
                    pend_addr_q <= coef_addr;
                    pend_data_q <= coef_data;
                end else begin
                    coef_q[coef_addr] <= coef_data;
                end
            end

            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        state_q      <= MAC;
                        k_q          <= '0;
                        acc_q        <= '0;
                        coef_ready_q <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == AW'(N_TAPS - 1)) begin
                        state_q <= ROUND;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ROUND: begin
                    data_out_q   <= DATA_WIDTH'(round_sat(64'(acc_q), COEF_FRAC, DATA_WIDTH));
                    data_valid_q <= 1'b1;
                    coef_ready_q <= 1'b1;
                    state_q      <= IDLE;
                    if (pend_we_q) begin
                        coef_q[pend_addr_q] <= pend_data_q;
                        pend_we_q           <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign coef_ready = coef_ready_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;

endmodule
